// File: rtl/logic_sweep_pkg.sv
// Shared types and helpers for the logic sweep self-test sequencer.
// Holds FSM encoding, last vector index and the golden F function.
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] VEC_LAST = 3'd7;

  function automatic logic golden_f(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & ~b) | (b & c);
  endfunction

endpackage

// File: rtl/sweep_edge_det.sv
// Registers start and emits a one-cycle pulse on its rising edge.
// Ports: clk, rst_n (async low), start in, rise out (combinational pulse).
module sweep_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic rise
);

  logic start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  end

  assign rise = start & ~start_q;

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps A/B/C through all 8 vectors and checks three F implementations.
// Ports: clk, rst_n, start, abort, f_* in; a/b/c, status and results out.
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_struct,
  input  logic       f_func,
  input  logic       f_behav,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_mask,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           nxt;
  logic [2:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic             start_edge;
  logic             g;
  logic [2:0]       m;
  logic             hit;
  logic [3:0]       err_nxt;

  sweep_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .rise  (start_edge)
  );

  assign {a, b, c} = vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_edge) nxt = SETTLE;
        SETTLE: if (cnt == CNT_LAST) nxt = CHECK;
        CHECK: nxt = (vec == VEC_LAST) ? DONE : SETTLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Mismatch vector is only meaningful in CHECK; hit gates it.
  always_comb begin
    g       = golden_f(vec[2], vec[1], vec[0]);
    m       = {f_behav, f_func, f_struct} ^ {3{g}};
    hit     = (state == CHECK) && (|m);
    err_nxt = err_count + {3'b000, hit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec              <= 3'd0;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 4'd0;
      fail_mask        <= 3'd0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else if (abort) begin
      // Partial results are kept for inspection.
      vec  <= 3'd0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            vec              <= 3'd0;
            cnt              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 4'd0;
            fail_mask        <= 3'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
          end
        end
        SETTLE: cnt <= cnt + 1'b1;
        CHECK: begin
          fail_mask <= fail_mask | m;
          err_count <= err_nxt;
          if (hit && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          if (vec == VEC_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_nxt == 4'd0);
          end else begin
            vec <= vec + 3'd1;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Self-checking bench for logic_sweep_ctrl with a result scoreboard.
// Two instances: default settle time and SETTLE_CYCLES = 1.
module tb_logic_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start, abort;
  logic       f_struct, f_func, f_behav;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_mask, ffv;
  logic       ffok;

  logic       start1, abort1;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] mask1, ffv1;
  logic       ffok1;

  int fault;
  logic [7:0] gold;

  assign f_struct = (fault == 1) ? 1'b0 : gold[{a, b, c}];
  assign f_func   = gold[{a, b, c}];
  assign f_behav  = (fault == 2) ? ~gold[{a, b, c}]
                                 : gold[{a, b, c}];

  logic_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .abort(abort),
    .f_struct(f_struct), .f_func(f_func),
    .f_behav(f_behav),
    .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask),
    .first_fail_vec(ffv), .first_fail_valid(ffok)
  );

  logic_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start(start1), .abort(abort1),
    .f_struct(gold[{a1, b1, c1}]),
    .f_func(gold[{a1, b1, c1}]),
    .f_behav(gold[{a1, b1, c1}]),
    .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1),
    .first_fail_vec(ffv1), .first_fail_valid(ffok1)
  );

  typedef struct {
    int         lat;
    logic [3:0] err;
    logic [2:0] mask;
    logic [2:0] ffv;
    logic       ffok;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push_exp(input int flt, input int settle);
    exp_t e;
    logic g;
    logic [2:0] f, m;
    e.lat = 8 * (settle + 1) + 1;
    e.err = 0; e.mask = 0; e.ffv = 0; e.ffok = 0;
    for (int v = 0; v < 8; v++) begin
      g = gold[v];
      f = {(flt == 2) ? ~g : g, g, (flt == 1) ? 1'b0 : g};
      m = f ^ {3{g}};
      e.mask |= m;
      if (m != 3'd0) begin
        e.err++;
        if (!e.ffok) begin
          e.ffv = v[2:0];
          e.ffok = 1'b1;
        end
      end
    end
    e.pass = (e.err == 0);
    sb.push_back(e);
  endtask

  task automatic sweep(input int flt, input bit repulse,
                       input string nm);
    exp_t e;
    int n;
    bit seen, did;
    int hold[8];
    fault = flt;
    push_exp(flt, 4);
    for (int i = 0; i < 8; i++) hold[i] = 0;
    start = 1'b1;
    n = 0; seen = 0; did = 0;
    while (!seen && n < 300) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (busy) hold[{a, b, c}]++;
      if (repulse && !did && {a, b, c} == 3'd2) begin
        start = 1'b1;
        did = 1'b1;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    check({nm, "_latency"}, n, e.lat);
    check({nm, "_err"}, 32'(err_count), 32'(e.err));
    check({nm, "_mask"}, 32'(fail_mask), 32'(e.mask));
    check({nm, "_ffv"}, 32'(ffv), 32'(e.ffv));
    check({nm, "_ffok"}, 32'(ffok), 32'(e.ffok));
    check({nm, "_pass"}, 32'(pass), 32'(e.pass));
    if (flt == 2)
      for (int v = 0; v < 8; v++)
        check($sformatf("%s_hold%0d", nm, v), hold[v], 5);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done_hold"}, 32'(done), 32'd1);
    check({nm, "_err_hold"}, 32'(err_count), 32'(e.err));
  endtask

  initial begin
    int n;
    bit found;
    gold = 8'b1011_1000;
    fault = 0;
    start = 0; abort = 0; start1 = 0; abort1 = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_abc", 32'({a, b, c}), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_mask", 32'(fail_mask), 0);
    check("rst_ffok", 32'(ffok), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    sweep(0, 0, "clean");
    sweep(1, 0, "struct0");
    sweep(2, 0, "behavinv");
    sweep(0, 1, "repulse");

    // abort at vec 4
    fault = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if ({a, b, c} == 3'd4) found = 1;
    end
    check("abort_reach_v4", 32'(found), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_abc", 32'({a, b, c}), 0);
    check("abort_pass", 32'(pass), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle", 32'(busy), 0);
    sweep(0, 0, "post_abort");

    // async reset mid-sweep
    fault = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if ({a, b, c} == 3'd5) found = 1;
    end
    check("rst_reach_v5", 32'(found), 1);
    check("rst_pre_err", 32'(err_count), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_abc", 32'({a, b, c}), 0);
    check("arst_err", 32'(err_count), 0);
    check("arst_mask", 32'(fail_mask), 0);
    check("arst_ffok", 32'(ffok), 0);
    check("arst_ffv", 32'(ffv), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fault = 0;
    @(posedge clk); #1;

    // SETTLE_CYCLES = 1 instance
    start1 = 1'b1;
    abort1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    abort1 = 1'b0;
    check("s1_both_busy", 32'(busy1), 0);
    repeat (3) @(posedge clk);
    #1;
    check("s1_both_idle", 32'(busy1), 0);
    check("s1_both_done", 32'(done1), 0);
    start1 = 1'b1;
    n = 0;
    found = 0;
    while (!found && n < 100) begin
      @(posedge clk); #1;
      n++;
      start1 = 1'b0;
      if (done1) found = 1;
    end
    check("s1_done_seen", 32'(found), 1);
    check("s1_latency", n, 17);
    check("s1_pass", 32'(pass1), 1);
    check("s1_err", 32'(err1), 0);
    check("s1_mask", 32'(mask1), 0);
    check("s1_ffok", 32'(ffok1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_sweep_ctrl.md
Name: logic_sweep_ctrl

Overview:
Self-test sequencer for the 3-input function block F = (A & ~B) | (B & C), which has structural, functional and behavioural outputs.
- Drives A/B/C through all 8 input vectors and waits a programmable settle time for each.
- Samples all three F implementations and compares them against an internal golden value.
- Reports pass/fail, error count and first failing vector to board LEDs and the top level.
- Sits between the board top (button/LED glue) and the function block instance.

Parameters:
SETTLE_CYCLES, 4, clk cycles each vector is held before sampling; legal range 1..255.
CNT_W, 8, settle counter width; must hold SETTLE_CYCLES-1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  synchronous to clk; a rising edge begins a sweep.
abort  input  1  synchronous to clk; level-sensitive; returns the block to IDLE.
f_struct  input  1  structural F from the function block.
f_func  input  1  functional F from the function block.
f_behav  input  1  behavioural F from the function block.
a  output  1  drive to function block input A.
b  output  1  drive to function block input B.
c  output  1  drive to function block input C.
busy  output  1  high in SETTLE and CHECK.
done  output  1  high in DONE.
pass  output  1  valid while done; 1 when err_count == 0.
err_count  output  4  number of vectors with at least one mismatching implementation (0..8).
fail_mask  output  3  sticky per-implementation fail flags: bit0 = struct, bit1 = func, bit2 = behav.
first_fail_vec  output  3  {a,b,c} of the first failing vector.
first_fail_valid  output  1  high once any mismatch has been recorded.

Behaviour:
- Reset (async assert, sync release): state = IDLE; vec = 0; {a,b,c} = 0; cnt = 0; busy = 0; done = 0; pass = 0; err_count = 0; fail_mask = 0; first_fail_vec = 0; first_fail_valid = 0; start_q = 0.
- Start edge: start_edge = start & ~start_q, where start_q is the registered start.
- All outputs are registered. {a,b,c} = vec, with a as the MSB.
- Golden value: g = (a & ~b) | (b & c). Truth table for vec 0..7 is 0,0,0,1,1,1,0,1.
- IDLE:
  - On start_edge & ~abort: clear all result outputs; vec = 0; cnt = 0; go to SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1, go to CHECK.
- CHECK (exactly 1 cycle):
  - Compute m = {f_behav, f_func, f_struct} ^ {3{g}}.
  - fail_mask |= m.
  - If |m: err_count increments. If first_fail_valid == 0, load first_fail_vec = vec and set first_fail_valid = 1.
  - If vec == 7, go to DONE.
  - Otherwise vec increments, cnt = 0, go to SETTLE.
- DONE:
  - done = 1; pass = (err_count == 0), reflecting the final count.
  - Results hold until the next start_edge, which clears them and restarts exactly as from IDLE.
- Timing: start_edge sampled in cycle N → busy = 1 from N+1; done = 1 at N+1+8*(SETTLE_CYCLES+1).
- start_edge while busy is ignored; no restart.
- abort has priority over everything except reset:
  - From any state, the next state is IDLE, busy = 0, done = 0, {a,b,c} = 0.
  - err_count, fail_mask and first_fail_* hold their partial values.
  - pass = 0.
- Simultaneous start_edge and abort: abort wins, state is IDLE.
- Reset mid-sweep: all outputs return to reset values immediately (asynchronously).
- err_count never wraps: its maximum is 8, which fits in 4 bits.
- f_* inputs are sampled only in CHECK and ignored in other states.

Decomposition:
Shared package logic_sweep_pkg holds:
- state encoding: IDLE = 2'd0, SETTLE = 2'd1, CHECK = 2'd2, DONE = 2'd3
- VEC_LAST = 3'd7
- golden function golden_f(a, b, c)

One natural sub-module, sweep_edge_det: start register plus rising-edge pulse. Everything else stays in logic_sweep_ctrl.

Test Plan:
- Correct function block, SETTLE_CYCLES = 4, one start pulse → done rises exactly 41 cycles after the start edge cycle; pass = 1, err_count = 0, fail_mask = 000, first_fail_valid = 0.
- f_struct stuck at 0 → err_count = 4, fail_mask = 001, first_fail_vec = 3'b011, pass = 0.
- f_behav inverted relative to golden → err_count = 8, fail_mask = 100, first_fail_vec = 0; a,b,c observed stepping 000→111 with each vector held 5 cycles.
- abort asserted while vec = 4 → next cycle busy = 0, done = 0, {a,b,c} = 000, state IDLE; a new start completes a full clean sweep with pass = 1.
- Second start pulse at vec = 2 is ignored (sweep still finishes at the original cycle); rst_n pulsed low at vec = 5 clears all outputs immediately.
- SETTLE_CYCLES = 1 → done at N+17; start and abort asserted in the same IDLE cycle → block stays in IDLE.
